fft_iter_core: RTL and testbench
================================

# fft_iter_core

Parametrised, in-place radix-2 DIT FFT/IFFT engine for N-point real input, complex output. Samples stream in through a valid/ready port and are stored in bit-reversed order. One time-shared butterfly then computes all log2(N) stages from an internal register array, and the bins stream out in natural order. It is the next-generation replacement for the fixed 16-point, eight-butterfly FFT datapath. It adds depth/width parameters, inverse mode, per-stage scaling and flow control.

## Interface
- N_POINTS, 16: transform size; power of two, 4..256.
- DATA_W, 16: width of each real/imag component, two's complement.
- TW_FRAC, 8: twiddle fraction bits. Twiddles are signed (TW_FRAC+8)-bit, Q(TW_FRAC), with 1.0 = 1<<TW_FRAC.
- CLK in 1: single clock, rising edge.
- RST in 1: asynchronous, active-high reset.
- in_valid in 1: input sample valid.
- in_ready out 1: core accepts a sample this cycle.
- in_data in DATA_W: real input sample; imaginary part is 0.
- in_inv in 1: 1 selects the inverse transform (conjugate twiddles). Sampled with the first sample of a frame.
- in_scale in 1: 1 divides every stage by 2, giving an overall 1/N. Sampled with the first sample of a frame.
- out_valid out 1: output bin valid.
- out_ready in 1: downstream accepts the bin.
- out_data out 2*DATA_W: bin packed as {re, im}.
- out_last out 1: asserted with bin N-1.
- busy out 1: high in CALC and UNLOAD.

## Operation
- The FSM has three states: LOAD, CALC and UNLOAD. Reset enters LOAD. L = log2(N_POINTS).
- **LOAD**
  - in_ready = 1.
  - Each accepted sample n (in_valid & in_ready) is written to mem[bitrev(n)] as {in_data, 0}.
  - in_inv and in_scale are latched when n = 0.
  - Acceptance of sample N-1 transitions to CALC.
- **CALC**
  - One butterfly per cycle, with stage s = 0..L-1 and butterfly j = 0..N/2-1.
  - Addressing: h = 1<<s, a = (j>>s)*2h + (j & (h-1)), b = a+h. Twiddle index k = (j & (h-1)) << (L-1-s).
  - The read of mem[a]/mem[b] is combinational. Results are written back to the same addresses at the clock edge. Pairs within a stage are disjoint, so there is no hazard.
  - After stage L-1, butterfly N/2-1, the FSM transitions to UNLOAD.
- **UNLOAD**
  - out_valid = 1, out_data = mem[m], out_last = (m == N-1).
  - m advances on out_valid & out_ready.
  - Acceptance of bin N-1 transitions to LOAD.
- **Twiddle generation**
  - W[k] = round(cos(2πk/N)·2^TW_FRAC) − j·round(sin(2πk/N)·2^TW_FRAC), with k < N/2, computed at elaboration.
  - Inverse mode negates the imaginary part.
  - For N=16, TW_FRAC=8: W[1] = {0x00ED, 0xFF9E} and W[4] = {0x0000, 0xFF00}.
- **Butterfly arithmetic**
  - Complex product t = b·W: full-precision products, then re/im are arithmetic-shifted right by TW_FRAC (floor) and truncated to DATA_W+1 bits.
  - a' = a+t and b' = a−t, each component computed in DATA_W+1 bits.
  - If scale: each result is shifted >>>1 (floor) to DATA_W bits.
  - Otherwise each result is truncated to the low DATA_W bits (wrap, no saturation).
- Reset mid-frame aborts the frame: state goes to LOAD, all counters go to 0, mem is cleared to 0, and latched mode bits go to 0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Load takes N accepted samples. in_valid gaps are allowed; in_data is ignored when in_ready=0.
- CALC takes exactly L·N/2 cycles, with no stall. For N=16 this is 32 cycles.
- in_ready falls on the edge that accepts sample N-1. busy rises on the same edge.
- out_valid rises L·N/2 edges later.
- out_data and out_last hold stable while out_valid & !out_ready.
- The edge accepting bin N-1 drops out_valid and busy and raises in_ready. There is no frame overlap.
- in_inv and in_scale changes outside sample 0 have no effect.

## Structure
- **Package fft_pkg** holds:
  - the state enum (LOAD/CALC/UNLOAD);
  - clog2 and bitrev functions;
  - the elaboration-time twiddle function (real math, returns the packed {re, im}).
- **Sub-module fft_bf_unit** is purely combinational. It contains the complex multiply, add/sub and optional scale, parametrised by DATA_W/TW_FRAC.
- **Top level** holds the FSM, the load/stage/butterfly/unload counters, the mem register array and the twiddle ROM (localparam array built from fft_pkg).

## Test plan
- **Impulse, no scale:** N=16, x[0]=1000, others 0, inv=0, scale=0 -> all 16 bins = {1000, 0}; out_last on bin 15 only.
- **DC:** all x=100, no scale -> bin0 = {1600, 0}, bins 1..15 = {0, 0}.
- **Scaled impulse:** x[0]=1024, scale=1 -> all bins = {64, 0}.
- **Twiddle and inverse check:** x[1]=256, others 0.
  - Forward: bin4 = {0x0000, 0xFF00} and bin2 = {181, −181}.
  - Same frame with inv=1: bin4 = {0x0000, 0x0100} and bin2 = {181, 181}.
- **Flow control:**
  - Random in_valid gaps and random out_ready stalls -> results identical to the stall-free run.
  - out_data stable during stalls.
  - out_valid rises exactly 32 cycles after the last sample is accepted.
- **Reset mid-operation:** assert RST in the 10th CALC cycle -> outputs immediately at reset values. The next full frame (impulse x[0]=5) yields all bins {5, 0}.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative radix-2 FFT core:
// FSM state encoding, integer log2, bit reversal and the twiddle generator.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CALC,
    ST_UNLOAD
  } fft_state_e;

  localparam real PI = 3.14159265358979323846;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int bitrev(input int value, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((value >> i) & 1);
    return r;
  endfunction

  // Taylor series keeps the twiddle ROM a pure constant function of plain
  // real arithmetic; 20 terms are exact to double precision for |x| <= pi.
  function automatic real cos_r(input real x);
    real term, sum;
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i <= 20; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real sin_r(input real x);
    real term, sum;
    term = x;
    sum  = x;
    for (int i = 1; i <= 20; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int round_r(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  // Forward twiddle W[k] = cos - j*sin, returned as {re[31:0], im[31:0]};
  // callers keep the low TW_FRAC+8 bits of each half.
  function automatic logic [63:0] twiddle(input int k, input int n, input int frac);
    real ang, one;
    int  re, im;
    one = 1.0;
    for (int i = 0; i < frac; i++) one = one * 2.0;
    ang = 2.0 * PI * real'(k) / real'(n);
    re  = round_r(cos_r(ang) * one);
    im  = -round_r(sin_r(ang) * one);
    return {re, im};
  endfunction

endpackage

// File: rtl/fft_bf_unit.sv
// Combinational radix-2 DIT butterfly: t = b*W, a' = a+t, b' = a-t, with an
// optional halving of both results for per-stage scaling.
module fft_bf_unit #(
  parameter int DATA_W  = 16,
  parameter int TW_FRAC = 8
) (
  input  logic [2*DATA_W-1:0]      a,
  input  logic [2*DATA_W-1:0]      b,
  input  logic [2*(TW_FRAC+8)-1:0] w,
  input  logic                     scale,
  output logic [2*DATA_W-1:0]      a_out,
  output logic [2*DATA_W-1:0]      b_out
);

  localparam int TW_W = TW_FRAC + 8;
  localparam int PW   = DATA_W + TW_W + 1;
  localparam int SUMW = DATA_W + 1;

  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [PW-1:0]     p_re, p_im;
  logic signed [SUMW-1:0]   t_re, t_im;
  logic signed [SUMW-1:0]   sum_re, sum_im, dif_re, dif_im;
  logic                     unused_prod;

  assign a_re = a[2*DATA_W-1:DATA_W];
  assign a_im = a[DATA_W-1:0];
  assign b_re = b[2*DATA_W-1:DATA_W];
  assign b_im = b[DATA_W-1:0];
  assign w_re = w[2*TW_W-1:TW_W];
  assign w_im = w[TW_W-1:0];

  // Full-precision complex product; PW bits hold the worst-case difference.
  assign p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
  assign p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);

  // Slicing above bit TW_FRAC is the floor shift plus truncation to SUMW bits.
  assign t_re = p_re[TW_FRAC +: SUMW];
  assign t_im = p_im[TW_FRAC +: SUMW];

  assign sum_re = SUMW'(a_re) + t_re;
  assign sum_im = SUMW'(a_im) + t_im;
  assign dif_re = SUMW'(a_re) - t_re;
  assign dif_im = SUMW'(a_im) - t_im;

  assign a_out = scale ? {sum_re[DATA_W:1], sum_im[DATA_W:1]}
                       : {sum_re[DATA_W-1:0], sum_im[DATA_W-1:0]};
  assign b_out = scale ? {dif_re[DATA_W:1], dif_im[DATA_W:1]}
                       : {dif_re[DATA_W-1:0], dif_im[DATA_W-1:0]};

  assign unused_prod = ^{p_re[TW_FRAC-1:0], p_re[PW-1:TW_FRAC+SUMW],
                         p_im[TW_FRAC-1:0], p_im[PW-1:TW_FRAC+SUMW]};

endmodule

// File: rtl/fft_iter_core.sv
// In-place iterative radix-2 DIT FFT/IFFT: bit-reversed load, one shared
// butterfly per cycle over all stages, natural-order unload with valid/ready.
module fft_iter_core
  import fft_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 16,
  parameter int TW_FRAC  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_inv,
  input  logic                in_scale,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int L    = clog2(N_POINTS);
  localparam int AW   = L;
  localparam int HALF = N_POINTS / 2;
  localparam int TW_W = TW_FRAC + 8;
  localparam int SW   = 4;

  typedef logic [HALF-1:0][2*TW_W-1:0] tw_rom_t;

  function automatic tw_rom_t build_tw_rom();
    tw_rom_t     rom;
    logic [63:0] w;
    for (int k = 0; k < HALF; k++) begin
      w      = twiddle(k, N_POINTS, TW_FRAC);
      rom[k] = {w[32 +: TW_W], w[0 +: TW_W]};
    end
    return rom;
  endfunction

  localparam tw_rom_t TW_ROM = build_tw_rom();

  fft_state_e          state_q, state_d;
  logic [AW-1:0]       load_cnt, unload_cnt;
  logic [AW-2:0]       bf_cnt;
  logic [SW-1:0]       stage_cnt;
  logic                inv_q, scale_q;
  logic [2*DATA_W-1:0] mem [N_POINTS];

  logic                load_fire, unload_fire, last_bf, last_stage;
  logic [AW-1:0]       load_addr, j_ext, h_mask, addr_a, addr_b;
  logic [AW-2:0]       tw_idx;
  logic [2*TW_W-1:0]   tw_raw, tw_eff;
  logic [TW_W-1:0]     tw_im;
  logic [2*DATA_W-1:0] bf_a, bf_b;

  assign load_fire   = (state_q == ST_LOAD) && in_valid;
  assign unload_fire = (state_q == ST_UNLOAD) && out_ready;
  assign last_bf     = bf_cnt == (AW-1)'(HALF - 1);
  assign last_stage  = stage_cnt == SW'(L - 1);

  // Butterfly addressing for stage s, butterfly j: h = 1<<s,
  // a = (j>>s)*2h + (j & (h-1)), b = a + h, k = (j & (h-1)) << (L-1-s).
  always_comb begin
    load_addr = AW'(bitrev(int'(load_cnt), L));
    j_ext     = AW'(bf_cnt);
    h_mask    = AW'((1 << stage_cnt) - 1);
    addr_a    = ((j_ext >> stage_cnt) << (stage_cnt + 1)) | (j_ext & h_mask);
    addr_b    = addr_a | AW'(1 << stage_cnt);
    tw_idx    = (AW-1)'((j_ext & h_mask) << (L - 1 - int'(stage_cnt)));
  end

  assign tw_raw = TW_ROM[tw_idx];
  assign tw_im  = tw_raw[TW_W-1:0];
  // Inverse transform uses the conjugate twiddle.
  assign tw_eff = {tw_raw[2*TW_W-1:TW_W], inv_q ? -tw_im : tw_im};

  fft_bf_unit #(
    .DATA_W  (DATA_W),
    .TW_FRAC (TW_FRAC)
  ) u_bf (
    .a     (mem[addr_a]),
    .b     (mem[addr_b]),
    .w     (tw_eff),
    .scale (scale_q),
    .a_out (bf_a),
    .b_out (bf_b)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks below use blocking ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && load_cnt == AW'(N_POINTS - 1)) state_d = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (last_stage && last_bf) state_d = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem[unload_cnt];
        out_last  = unload_cnt == AW'(N_POINTS - 1);
        if (out_ready && out_last) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Counters wrap naturally at their power-of-two sizes, so each is back at
  // zero when its phase ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt   <= '0;
      unload_cnt <= '0;
      bf_cnt     <= '0;
      stage_cnt  <= '0;
      inv_q      <= 1'b0;
      scale_q    <= 1'b0;
    end else begin
      if (load_fire) begin
        load_cnt <= load_cnt + 1'b1;
        if (load_cnt == '0) begin
          inv_q   <= in_inv;
          scale_q <= in_scale;
        end
      end
      if (state_q == ST_CALC) begin
        bf_cnt <= bf_cnt + 1'b1;
        if (last_bf) stage_cnt <= last_stage ? '0 : stage_cnt + 1'b1;
      end
      if (unload_fire) unload_cnt <= unload_cnt + 1'b1;
    end
  end

  // NOTE: mem is a plain register array rather than a RAM macro, so clearing
  // it on reset is legal and aborts a frame without leaving stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_POINTS; i++) mem[i] <= '0;
    end else if (load_fire) begin
      mem[load_addr] <= {in_data, {DATA_W{1'b0}}};
    end else if (state_q == ST_CALC) begin
      mem[addr_a] <= bf_a;
      mem[addr_b] <= bf_b;
    end
  end

endmodule

// File: tb/tb_fft_iter_core.sv
// Directed, table-driven bench for fft_iter_core (N=16, DATA_W=16, TW_FRAC=8)
// with hand-computed spectra, flow-control and mid-calculation reset sequences.
module tb_fft_iter_core;

  localparam int N  = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_inv;
  logic          in_scale;
  logic          out_valid;
  logic          out_ready;
  logic [2*DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int id;
    bit inv;
    bit scale;
    int x0;
    int x1;
    int dc;
    int exp_re[N];
    int exp_im[N];
  } frame_t;

  frame_t frames[6];

  // Q8 twiddles for N=16, k = 0..7 (round(cos*256), -round(sin*256)).
  int wre[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int wim[8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  fft_iter_core #(
    .N_POINTS (N),
    .DATA_W   (DW),
    .TW_FRAC  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .in_scale  (in_scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic frame_t mk(input int id, input bit inv, input bit scale,
                                input int x0, input int x1, input int dc);
    frame_t f;
    f.id = id; f.inv = inv; f.scale = scale;
    f.x0 = x0; f.x1 = x1; f.dc = dc;
    for (int i = 0; i < N; i++) begin
      f.exp_re[i] = 0;
      f.exp_im[i] = 0;
    end
    return f;
  endfunction

  function automatic int sample(input frame_t f, input int n);
    return (n == 0 ? f.x0 : 0) + (n == 1 ? f.x1 : 0) + f.dc;
  endfunction

  task automatic load_frame(input frame_t f, input bit gaps);
    int n = 0;
    int guard = 0;
    while (n < N && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = 16'(sample(f, n));
        in_inv   = (n == 0 || !gaps) ? f.inv   : 1'($urandom_range(0, 1));
        in_scale = (n == 0 || !gaps) ? f.scale : 1'($urandom_range(0, 1));
      end
      if (in_valid && in_ready) n++;
    end
    if (n < N) check($sformatf("f%0d load_timeout", f.id), 32'(n), 32'(N));
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("f%0d busy_after_load", f.id), 32'(busy), 32'd1);
    check($sformatf("f%0d in_ready_after_load", f.id), 32'(in_ready), 32'd0);
  endtask

  task automatic wait_out(input frame_t f);
    int c = 0;
    while (!out_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("f%0d calc_latency", f.id), 32'(c), 32'd32);
  endtask

  task automatic unload_frame(input frame_t f, input bit stalls);
    int m = 0;
    int guard = 0;
    while (m < N && guard < 1000) begin
      out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      check($sformatf("f%0d bin%0d valid", f.id, m), 32'(out_valid), 32'd1);
      check($sformatf("f%0d bin%0d data", f.id, m), out_data,
            {16'(f.exp_re[m]), 16'(f.exp_im[m])});
      check($sformatf("f%0d bin%0d last", f.id, m), 32'(out_last), 32'(m == N - 1));
      if (out_ready) m++;
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    check($sformatf("f%0d out_valid_after", f.id), 32'(out_valid), 32'd0);
    check($sformatf("f%0d busy_after", f.id), 32'(busy), 32'd0);
    check($sformatf("f%0d in_ready_after", f.id), 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input frame_t f, input bit gaps, input bit stalls);
    load_frame(f, gaps);
    wait_out(f);
    unload_frame(f, stalls);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_data"},  out_data,       32'd0);
    check({tag, " out_last"},  32'(out_last),  32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    // Impulse, DC, scaled impulse, x[1]=256 forward and inverse, impulse of 5.
    frames[0] = mk(0, 1'b0, 1'b0, 1000, 0, 0);
    frames[1] = mk(1, 1'b0, 1'b0, 0, 0, 100);
    frames[2] = mk(2, 1'b0, 1'b1, 1024, 0, 0);
    frames[3] = mk(3, 1'b0, 1'b0, 0, 256, 0);
    frames[4] = mk(4, 1'b1, 1'b0, 0, 256, 0);
    frames[5] = mk(5, 1'b0, 1'b0, 5, 0, 0);
    for (int i = 0; i < N; i++) begin
      frames[0].exp_re[i] = 1000;
      frames[2].exp_re[i] = 64;
      frames[5].exp_re[i] = 5;
    end
    frames[1].exp_re[0] = 1600;
    for (int k = 0; k < 8; k++) begin
      frames[3].exp_re[k]     =  wre[k];
      frames[3].exp_im[k]     =  wim[k];
      frames[3].exp_re[k + 8] = -wre[k];
      frames[3].exp_im[k + 8] = -wim[k];
      frames[4].exp_re[k]     =  wre[k];
      frames[4].exp_im[k]     = -wim[k];
      frames[4].exp_re[k + 8] = -wre[k];
      frames[4].exp_im[k + 8] =  wim[k];
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    in_scale  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(frames[i], 1'b0, 1'b0);

    // Flow control: random input gaps with mode bits toggling after sample 0,
    // and random output stalls; every stalled cycle rechecks the held bin.
    run_frame(frames[3], 1'b1, 1'b1);
    run_frame(frames[4], 1'b1, 1'b1);

    // Reset in the 10th CALC cycle, then a clean impulse frame.
    load_frame(frames[3], 1'b0);
    repeat (9) @(negedge clk);
    check("pre_reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_calc_reset");
    @(negedge clk);
    rst = 1'b0;
    run_frame(frames[5], 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
